// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-2 Booth multiplier control path.
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  // {Q[0], Q[-1]} patterns that request an accumulator update
  localparam logic [1:0] ADD = 2'b01;
  localparam logic [1:0] SUB = 2'b10;

  // Smallest width able to index 0..value-1 (never less than one bit)
  function automatic int CeilLog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/booth_step_counter.sv
// Booth iteration counter: cleared on load, advanced once per shift,
// wraps to zero after the final iteration and flags that final iteration.
module booth_step_counter
  import booth_pkg::*;
#(
  parameter int WORD_LENGTH = 16,
  parameter int CNT_BITS    = CeilLog2(WORD_LENGTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                inc,
  output logic [CNT_BITS-1:0] step,
  output logic                last_step
);

  localparam logic [CNT_BITS-1:0] LastStep = CNT_BITS'(WORD_LENGTH - 1);

  logic [CNT_BITS-1:0] step_q;
  logic [CNT_BITS-1:0] step_d;

  // Clear wins over increment; increment wraps after the final iteration
  always_comb begin
    step_d = step_q;
    if (clr) begin
      step_d = '0;
    end else if (inc) begin
      if (step_q == LastStep) begin
        step_d = '0;
      end else begin
        step_d = step_q + 1'b1;
      end
    end
  end

  // Step register with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end

  assign step      = step_q;
  assign last_step = (step_q == LastStep);

endmodule

// File: rtl/booth_sequencer.sv
// Control FSM for the radix-2 Booth multiplier: start/done handshake with
// the host and one-hot load/add/sub/shift strobes to the datapath.
module booth_sequencer
  import booth_pkg::*;
#(
  parameter int WORD_LENGTH = 16,
  parameter int CNT_BITS    = CeilLog2(WORD_LENGTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          q_pair,
  input  logic                done_ack,
  output logic                ready,
  output logic                load,
  output logic                add_en,
  output logic                sub_en,
  output logic                shift_en,
  output logic                done,
  output logic [CNT_BITS-1:0] step
);

  state_t state_q;
  state_t state_d;
  logic   last_step;
  logic   cnt_clr;
  logic   cnt_inc;

  // Abort leaves the counter at zero so the next run starts clean
  assign cnt_clr = (state_q == LOAD) || abort;
  assign cnt_inc = (state_q == SHIFT);

  booth_step_counter #(
    .WORD_LENGTH(WORD_LENGTH),
    .CNT_BITS   (CNT_BITS)
  ) u_step_counter (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .step     (step),
    .last_step(last_step)
  );

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: abort beats start and done_ack from every busy state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = abort ? IDLE : EVAL;
      end
      EVAL: begin
        state_d = abort ? IDLE : SHIFT;
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (last_step) begin
          state_d = DONE;
        end else begin
          state_d = EVAL;
        end
      end
      DONE: begin
        if (abort || done_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes decoded straight from the registered state (add/sub also from q_pair)
  always_comb begin
    ready    = 1'b0;
    load     = 1'b0;
    add_en   = 1'b0;
    sub_en   = 1'b0;
    shift_en = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE:  ready    = 1'b1;
      LOAD:  load     = 1'b1;
      EVAL: begin
        add_en = (q_pair == ADD);
        sub_en = (q_pair == SUB);
      end
      SHIFT: shift_en = 1'b1;
      DONE:  done     = 1'b1;
      default: begin
        ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_sequencer.sv
// Self-checking bench for booth_sequencer: three builds (WORD_LENGTH 2, 16, 32)
// share one stimulus stream and are compared every cycle against a
// cycle-index reference model of the Booth control schedule.
module tb_booth_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic       doneAck;
  logic [1:0] qPair;

  logic       ready2, load2, add2, sub2, shift2, done2;
  logic [0:0] step2;
  logic       ready16, load16, add16, sub16, shift16, done16;
  logic [3:0] step16;
  logic       ready32, load32, add32, sub32, shift32, done32;
  logic [4:0] step32;

  int checkCount = 0;
  int errorCount = 0;

  int wlTab[3];
  bit busyM[3];
  int cycM[3];

  int mCyc;
  int doneRise[3];
  int shiftCnt[3];
  int addSubCnt[3];

  logic [1:0] pat[4];

  always #5 clk = ~clk;

  booth_sequencer #(.WORD_LENGTH(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .q_pair(qPair),
    .done_ack(doneAck), .ready(ready2), .load(load2), .add_en(add2),
    .sub_en(sub2), .shift_en(shift2), .done(done2), .step(step2)
  );

  booth_sequencer #(.WORD_LENGTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .q_pair(qPair),
    .done_ack(doneAck), .ready(ready16), .load(load16), .add_en(add16),
    .sub_en(sub16), .shift_en(shift16), .done(done16), .step(step16)
  );

  booth_sequencer #(.WORD_LENGTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .q_pair(qPair),
    .done_ack(doneAck), .ready(ready32), .load(load32), .add_en(add32),
    .sub_en(sub32), .shift_en(shift32), .done(done32), .step(step32)
  );

  // Packed observation: [13] ready [12] load [11] add [10] sub [9] shift [8] done [7:0] step
  function automatic logic [31:0] getObs(input int k);
    case (k)
      0:       return {18'b0, ready2,  load2,  add2,  sub2,  shift2,  done2,  8'(step2)};
      1:       return {18'b0, ready16, load16, add16, sub16, shift16, done16, 8'(step16)};
      2:       return {18'b0, ready32, load32, add32, sub32, shift32, done32, 8'(step32)};
      default: return 32'h0;
    endcase
  endfunction

  // Reference: cycle c of a run is 1 for load, then EVAL on even and SHIFT on
  // odd cycles up to 2*WL+1, then done from 2*WL+2 onward.
  function automatic logic [31:0] modelOut(input int k);
    int   wl;
    int   c;
    bit   busy;
    bit   inLoop;
    logic rdy, ld, ad, sb, sh, dn;
    int   st;
    wl     = wlTab[k];
    c      = cycM[k];
    busy   = busyM[k];
    inLoop = busy && (c >= 2) && (c <= 2 * wl + 1);
    rdy    = !busy;
    ld     = busy && (c == 1);
    sh     = inLoop && (c % 2 == 1);
    ad     = inLoop && (c % 2 == 0) && (qPair == 2'b01);
    sb     = inLoop && (c % 2 == 0) && (qPair == 2'b10);
    dn     = busy && (c >= 2 * wl + 2);
    st     = inLoop ? (c - 2) / 2 : 0;
    return {18'b0, rdy, ld, ad, sb, sh, dn, st[7:0]};
  endfunction

  task automatic modelStep(input int k);
    if (!busyM[k]) begin
      if (start && !abort) begin
        busyM[k] = 1'b1;
        cycM[k]  = 1;
      end
    end else if (abort) begin
      busyM[k] = 1'b0;
    end else if (cycM[k] >= 2 * wlTab[k] + 2) begin
      if (doneAck) begin
        busyM[k] = 1'b0;
      end
    end else begin
      cycM[k] = cycM[k] + 1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic startMeasure();
    mCyc = 0;
    for (int k = 0; k < 3; k++) begin
      doneRise[k]  = -1;
      shiftCnt[k]  = 0;
      addSubCnt[k] = 0;
    end
  endtask

  task automatic reportMeasure(input string tag);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("%s doneAt wl%0d", tag, wlTab[k]), doneRise[k], 2 * wlTab[k] + 2);
      checkOutput($sformatf("%s shifts wl%0d", tag, wlTab[k]), shiftCnt[k], wlTab[k]);
      checkOutput($sformatf("%s addsub wl%0d", tag, wlTab[k]), addSubCnt[k], 0);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check, advance the model
  task automatic applyStimulus(input logic s, input logic a, input logic [1:0] q,
                               input logic ack, input string tag);
    logic [31:0] obs;
    start   = s;
    abort   = a;
    qPair   = q;
    doneAck = ack;
    #1;
    for (int k = 0; k < 3; k++) begin
      obs = getObs(k);
      checkOutput($sformatf("%s wl%0d", tag, wlTab[k]), obs, modelOut(k));
      if (doneRise[k] < 0) begin
        if (obs[8]) doneRise[k] = mCyc;
        if (obs[9]) shiftCnt[k]++;
        if (obs[11] || obs[10]) addSubCnt[k]++;
      end
    end
    mCyc++;
    @(posedge clk);
    for (int k = 0; k < 3; k++) modelStep(k);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; outputs must respond at once
  task automatic applyReset(input string tag);
    start   = 1'b0;
    abort   = 1'b0;
    doneAck = 1'b0;
    qPair   = 2'b00;
    #2;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      busyM[k] = 1'b0;
      cycM[k]  = 0;
      checkOutput($sformatf("%s wl%0d", tag, wlTab[k]), getObs(k), modelOut(k));
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    wlTab[0] = 2;
    wlTab[1] = 16;
    wlTab[2] = 32;
    pat[0] = 2'b01;
    pat[1] = 2'b10;
    pat[2] = 2'b11;
    pat[3] = 2'b00;
    reset   = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    doneAck = 1'b0;
    qPair   = 2'b00;
    startMeasure();
    @(negedge clk);
    applyReset("rst0");

    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, "idle");

    applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, "preRst");
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 2'b01, 1'b0, "preRst");
    applyReset("rstMid");
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, "postRst");

    startMeasure();
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, "q00");
    for (int i = 1; i < 70; i++) applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, "q00");
    reportMeasure("q00");
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, "q00ack");
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, "q00idle");

    for (int i = 0; i < 70; i++)
      applyStimulus(i == 0, 1'b0, pat[(i / 2 + 3) % 4], 1'b0, "pattern");
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, "patAck");

    applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, "abortRun");
    for (int i = 1; i < 16; i++) applyStimulus(1'b0, 1'b0, 2'b01, 1'b0, "abortRun");
    checkOutput("abortStep", 32'(step16), 32'd7);
    checkOutput("abortEval", {28'b0, load16, add16, shift16, done16}, 32'b0100);
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, "abortCyc");
    checkOutput("afterAbort", {26'b0, ready16, done16, step16}, {26'b0, 1'b1, 1'b0, 4'd0});
    startMeasure();
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, "rerun");
    for (int i = 1; i < 70; i++) applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, "rerun");
    reportMeasure("rerun");
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, "rerunAck");

    for (int i = 0; i < 100; i++)
      applyStimulus(1'b1, 1'b0, 2'($urandom_range(0, 3)), (i == 40) || (i == 80), "startHeld");

    for (int i = 0; i < 800; i++) begin
      if (i == 400) applyReset("rstRand");
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
                    2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
